// File: rtl/input_port_rc_if.sv
// ---------------------------------------------------------------------------
// input_port_rc_if
// Groups the flit handshake of a router input port: the upstream push side
// (in_valid/in_data/full), the switch-allocator side (label/data_out/ready)
// and status (count/overflow_err).
//   master : upstream sender + allocator (drives in_valid, in_data, ready)
//   slave  : the input port itself (drives full, label, data_out, count,
//            overflow_err)
// ---------------------------------------------------------------------------
interface input_port_rc_if #(
    parameter int DATASIZE = 40,
    parameter int WIDTH    = 3
);
    logic                in_valid;
    logic [DATASIZE-1:0] in_data;
    logic                full;
    logic [3:0]          label;
    logic [DATASIZE-1:0] data_out;
    logic                ready;
    logic [WIDTH:0]      count;
    logic                overflow_err;

    modport master (
        output in_valid,
        output in_data,
        output ready,
        input  full,
        input  label,
        input  data_out,
        input  count,
        input  overflow_err
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  ready,
        output full,
        output label,
        output data_out,
        output count,
        output overflow_err
    );
endinterface

// File: rtl/input_port_rc.sv
// ---------------------------------------------------------------------------
// input_port_rc
// Router input port: a DEPTH-entry first-word-fall-through flit FIFO with an
// XY route computation on the head flit, feeding the switch allocator.
// Ports:
//   clk    - clock
//   rst_n  - asynchronous active-low reset (discards all stored flits)
//   bus    - input_port_rc_if.slave:
//              in_valid/in_data  upstream push, refused while full
//              full              FIFO full, back-pressure to upstream
//              label             {W,N,E,S} route of head, 4'b0000 local,
//                                4'b1111 when no flit is present
//              data_out          head flit (zero when empty)
//              ready             allocator pops the head flit
//              count             occupancy 0..DEPTH
//              overflow_err      sticky: push attempted while full
// ---------------------------------------------------------------------------
module input_port_rc #(
    parameter int         DEPTH    = 8,
    parameter int         WIDTH    = 3,
    parameter int         DATASIZE = 40,
    parameter logic [1:0] X_COORD  = 2'd0,
    parameter logic [1:0] Y_COORD  = 2'd0
) (
    input logic              clk,
    input logic              rst_n,
    input_port_rc_if.slave   bus
);

    localparam logic [WIDTH:0]   L_DEPTH   = (WIDTH+1)'(DEPTH);
    localparam logic [WIDTH:0]   L_CNT_ONE = (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0] L_PTR_ONE = WIDTH'(1);

    logic [DATASIZE-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0]    r_wr_ptr;
    logic [WIDTH-1:0]    r_rd_ptr;
    logic [WIDTH:0]      r_count;
    logic                r_overflow_err;

    logic                w_empty;
    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic [DATASIZE-1:0] w_head;
    logic [1:0]          w_dx;
    logic [1:0]          w_dy;
    logic [3:0]          w_label;

    // Status is decoded only from the registered occupancy; a pop in the
    // same cycle does not free a slot for a push while full.
    assign w_empty = (r_count == {(WIDTH+1){1'b0}});
    assign w_full  = (r_count == L_DEPTH);
    assign w_push  = bus.in_valid & ~w_full;
    assign w_pop   = bus.ready & ~w_empty;

    // Flit storage; no reset so the array maps onto plain registers/RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.in_data;
        end
    end

    // Pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr       <= {WIDTH{1'b0}};
            r_rd_ptr       <= {WIDTH{1'b0}};
            r_count        <= {(WIDTH+1){1'b0}};
            r_overflow_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + L_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + L_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + L_CNT_ONE;
                2'b01:   r_count <= r_count - L_CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (bus.in_valid && w_full) begin
                r_overflow_err <= 1'b1;
            end
        end
    end

    // Head flit straight from storage; forced to zero when empty so the
    // allocator never sees stale contents.
    assign w_head = w_empty ? {DATASIZE{1'b0}} : r_mem[r_rd_ptr];
    assign w_dx   = w_head[35:34];
    assign w_dy   = w_head[33:32];

    // XY routing: resolve X first, then Y; at most one direction bit set.
    always_comb begin
        w_label = 4'b1111;
        if (w_empty) begin
            w_label = 4'b1111;
        end else if (w_dx > X_COORD) begin
            w_label = 4'b0010;
        end else if (w_dx < X_COORD) begin
            w_label = 4'b1000;
        end else if (w_dy > Y_COORD) begin
            w_label = 4'b0001;
        end else if (w_dy < Y_COORD) begin
            w_label = 4'b0100;
        end else begin
            w_label = 4'b0000;
        end
    end

    assign bus.full         = w_full;
    assign bus.label        = w_label;
    assign bus.data_out     = w_head;
    assign bus.count        = r_count;
    assign bus.overflow_err = r_overflow_err;

endmodule

// File: tb/tb_input_port_rc.sv
module tb_input_port_rc;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [39:0] q[$];
    logic        exp_ovf;

    input_port_rc_if #(.DATASIZE(40), .WIDTH(3)) bus ();

    input_port_rc #(
        .DEPTH(8), .WIDTH(3), .DATASIZE(40), .X_COORD(2'd0), .Y_COORD(2'd0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference XY route for a router at (0,0).
    function automatic logic [3:0] route(input logic [39:0] f);
        logic [1:0] dx;
        logic [1:0] dy;
        dx = f[35:34];
        dy = f[33:32];
        if (dx > 2'd0)      return 4'b0010;
        else if (dx < 2'd0) return 4'b1000;
        else if (dy > 2'd0) return 4'b0001;
        else if (dy < 2'd0) return 4'b0100;
        else                return 4'b0000;
    endfunction

    function automatic logic [39:0] mkflit(input logic [3:0] dst, input logic [21:0] val);
        return {4'h3, dst, 8'h5a, val, 2'b10};
    endfunction

    // One clock: check current outputs against the model, drive inputs,
    // then update the scoreboard after the edge.
    task automatic step(input logic v, input logic [39:0] d, input logic r, input string tag);
        logic do_pop;
        logic do_push;
        logic [39:0] exp_d;
        logic [3:0]  exp_l;
        @(negedge clk);
        if (q.size() == 0) begin
            exp_d = 40'd0;
            exp_l = 4'b1111;
        end else begin
            exp_d = q[0];
            exp_l = route(q[0]);
        end
        checks++;
        if (bus.count !== 4'(q.size())) begin
            failures++;
            $display("FAIL %s count: got %0d want %0d", tag, bus.count, q.size());
        end
        checks++;
        if (bus.full !== (q.size() == 8)) begin
            failures++;
            $display("FAIL %s full: got %b want %b", tag, bus.full, (q.size() == 8));
        end
        checks++;
        if (bus.overflow_err !== exp_ovf) begin
            failures++;
            $display("FAIL %s overflow_err: got %b want %b", tag, bus.overflow_err, exp_ovf);
        end
        checks++;
        if (bus.label !== exp_l) begin
            failures++;
            $display("FAIL %s label: got %b want %b", tag, bus.label, exp_l);
        end
        checks++;
        if (bus.data_out !== exp_d) begin
            failures++;
            $display("FAIL %s data_out: got %h want %h", tag, bus.data_out, exp_d);
        end
        bus.in_valid = v;
        bus.in_data  = d;
        bus.ready    = r;
        do_pop  = r && (q.size() > 0);
        do_push = v && (q.size() < 8);
        if (v && q.size() == 8) exp_ovf = 1'b1;
        @(posedge clk);
        #1;
        if (do_pop)  void'(q.pop_front());
        if (do_push) q.push_back(d);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 8; i++) begin
            if (q.size() > 0) step(1'b0, 40'd0, 1'b1, tag);
        end
        step(1'b0, 40'd0, 1'b0, {tag, "_empty"});
    endtask

    // Assert reset away from any edge and check outputs before the next edge.
    task automatic reset_check(input string tag);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.ready    = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.count !== 4'd0) begin
            failures++;
            $display("FAIL %s count: got %0d want 0", tag, bus.count);
        end
        checks++;
        if (bus.label !== 4'b1111) begin
            failures++;
            $display("FAIL %s label: got %b want 1111", tag, bus.label);
        end
        checks++;
        if (bus.full !== 1'b0) begin
            failures++;
            $display("FAIL %s full: got %b want 0", tag, bus.full);
        end
        checks++;
        if (bus.overflow_err !== 1'b0) begin
            failures++;
            $display("FAIL %s overflow_err: got %b want 0", tag, bus.overflow_err);
        end
        q.delete();
        exp_ovf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        step(1'b0, 40'd0, 1'b0, "reset_idle");
        for (int i = 0; i < 5; i++) step(1'b1, mkflit(4'(i), 22'(i + 100)), 1'b0, "reset_fill");
        step(1'b0, 40'd0, 1'b0, "reset_cnt5");
        reset_check("reset_mid");
        step(1'b0, 40'd0, 1'b0, "reset_after");
    endtask

    task automatic test_route();
        step(1'b1, mkflit(4'b0100, 22'h1), 1'b0, "route_push_e");
        step(1'b1, mkflit(4'b0001, 22'h2), 1'b0, "route_push_s");
        step(1'b1, mkflit(4'b0000, 22'h3), 1'b0, "route_push_l");
        step(1'b1, mkflit(4'b1110, 22'h4), 1'b0, "route_push_e2");
        step(1'b0, 40'd0, 1'b1, "route_pop_e");
        step(1'b0, 40'd0, 1'b1, "route_pop_s");
        step(1'b0, 40'd0, 1'b1, "route_pop_l");
        step(1'b0, 40'd0, 1'b1, "route_pop_e2");
        step(1'b0, 40'd0, 1'b1, "route_ready_empty");
        step(1'b0, 40'd0, 1'b0, "route_empty");
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= 8; i++) step(1'b1, 40'(i), 1'b0, "fill_push");
        step(1'b1, 40'h09, 1'b0, "fill_overflow");
        step(1'b0, 40'd0, 1'b0, "fill_after_ovf");
        drain("fill_drain");
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 6; i++) step(1'b1, mkflit(4'(i * 3), 22'(i + 200)), 1'b0, "wrap_push6");
        drain("wrap_pop6");
        for (int i = 0; i < 5; i++) step(1'b1, mkflit(4'(i * 5), 22'(i + 300)), 1'b0, "wrap_push5");
        step(1'b0, 40'd0, 1'b0, "wrap_cnt5");
        drain("wrap_drain");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) step(1'b1, mkflit(4'(i), 22'(i + 400)), 1'b0, "b2b_fill");
        for (int i = 0; i < 10; i++)
            step(1'b1, mkflit(4'($urandom_range(0, 15)), 22'($urandom)), 1'b1, "b2b_pushpop");
        step(1'b0, 40'd0, 1'b0, "b2b_cnt3");
        drain("b2b_drain");
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 8; i++) step(1'b1, mkflit(4'(15 - i), 22'(i + 500)), 1'b0, "fullpop_fill");
        step(1'b1, 40'hAB, 1'b1, "fullpop_both");
        step(1'b0, 40'd0, 1'b0, "fullpop_cnt7");
        step(1'b0, 40'd0, 1'b1, "fullpop_pop1");
        step(1'b1, mkflit(4'hC, 22'h77), 1'b0, "fullpop_push");
        step(1'b0, 40'd0, 1'b0, "fullpop_hold");
        reset_check("fullpop_reset");
        step(1'b0, 40'd0, 1'b0, "fullpop_post_reset");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        exp_ovf  = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 40'd0;
        bus.ready    = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_route();
        test_fill_overflow();
        test_wrap();
        test_back_to_back();
        test_full_pop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/input_port_rc.md
Name: input_port_rc

Overview:
- Router input-port unit that sits directly upstream of the switch allocator.
- Buffers incoming flits from a neighbour or the local core in a DEPTH-entry FIFO.
- Computes the XY route label for the head flit and presents label plus data to the allocator with first-word-fall-through timing.
- Pops the head flit when the allocator returns ready; exports full to the upstream sender.

Parameters:
DEPTH, 8, FIFO entries; power of two, equal to 2**WIDTH
WIDTH, 3, pointer width
DATASIZE, 40, flit width: [39:36] src, [35:32] dst, [31:24] timestamp, [23:2] data, [1:0] type
X_COORD, 0, this router's x coordinate (2 bits)
Y_COORD, 0, this router's y coordinate (2 bits)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  upstream flit valid
in_data  input  DATASIZE  upstream flit
full  output  1  FIFO full; upstream must not push
label  output  4  route label for head flit {W,N,E,S}; 4'b0000 = local; 4'b1111 = no flit
data_out  output  DATASIZE  head flit
ready  input  1  allocator accepts head flit this cycle
count  output  WIDTH+1  current occupancy
overflow_err  output  1  sticky error flag: push attempted while full

Behaviour:
- Reset (async): wr_ptr, rd_ptr and count go to 0. full=0, label=4'b1111, overflow_err=0. data_out is don't-care, but the implementation drives 0 when empty. Reset mid-operation discards all stored flits.
- Storage: DEPTH x DATASIZE register array; pointers are WIDTH bits and wrap naturally from DEPTH-1 to 0. count is WIDTH+1 bits.
- empty = (count==0); full = (count==DEPTH). Both are decoded from the registered count.
- Push: occurs when in_valid && !full, on the clock edge. in_data is written at wr_ptr and wr_ptr increments.
- Pop: occurs when ready && !empty, on the clock edge. rd_ptr increments.
- ready while empty is ignored: no pointer move and no underflow.
- Simultaneous push and pop: both occur and count is unchanged.
- When full, a push is rejected even if a pop occurs in the same cycle. Full is not bypassed.
- Count update: +1 on push only, -1 on pop only, unchanged otherwise.
- Overflow: in_valid && full sets overflow_err, which stays set until reset. The flit is dropped and FIFO contents are unchanged.
- Head presentation: combinational from mem[rd_ptr] (first-word fall-through).
  - A flit pushed into an empty FIFO at edge N appears on data_out/label after edge N, i.e. in cycle N+1.
  - Push-to-head latency is 1 cycle; there is no same-cycle bypass.
- Route computation (XY, combinational on data_out[35:32]), with dx = dst[3:2], dy = dst[1:2-2] i.e. dst[1:0]:
  - empty -> 4'b1111
  - dx > X_COORD -> 4'b0010 (E)
  - dx < X_COORD -> 4'b1000 (W)
  - dx == X_COORD and dy > Y_COORD -> 4'b0001 (S)
  - dx == X_COORD and dy < Y_COORD -> 4'b0100 (N)
  - both equal -> 4'b0000 (local)
  - Exactly one or zero bits are set whenever a flit is present.
- Comparisons are unsigned 2-bit. No flit field is modified in transit.
- label and data_out must be stable for the whole cycle: they are derived only from registers, with no combinational path from ready.

Test Plan:
- Reset check: assert rst_n=0 mid-traffic with count=5 -> count=0, label=4'b1111, full=0 and overflow_err=0 immediately, without waiting for a clock edge.
- Route decode at X_COORD=0, Y_COORD=0:
  - push dst=4'b0100 -> label=4'b0010
  - push dst=4'b0001 -> label=4'b0001
  - push dst=4'b0000 -> label=4'b0000
  - Pop each with ready=1 and confirm the labels appear in push order.
- Fill and overflow: push 8 flits 0x01..0x08 with ready=0 -> full=1, count=8. A 9th push with value 0x09 -> overflow_err=1, FIFO unchanged. Then ready=1 for 8 cycles -> data_out sequence 0x01..0x08, then label=4'b1111.
- Wrap-around: push 6, pop 6, then push 5 -> pointers wrap past 7. data_out order matches push order and count=5.
- Simultaneous push/pop at count=3 held for 10 cycles -> count stays 3, full never asserts, output order is preserved.
- Full plus simultaneous pop: at count=8 drive in_valid=1 and ready=1 -> pop occurs, push is rejected, overflow_err=1, count=7.
